// File: rtl/serial_pkg.sv
// Shared types and helpers for the counter-gated serial transmitter.
package serial_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } tx_state_t;

    // Effective frame length: 0 means a full byte, anything above a byte is clamped.
    function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] len);
        logic [CNT_W-1:0] res;
        if ((len == '0) || (len > CNT_W'(DATA_W))) begin
            res = CNT_W'(DATA_W);
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage : serial_pkg

// File: rtl/bit_down_counter.sv
// Loadable down-counter that tracks how many bits of the frame remain.
module bit_down_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] init,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load has priority over counting; the counter never wraps below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = init;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == CNT_W'(1));

endmodule : bit_down_counter

// File: rtl/serial_tx_8_bit.sv
// MSB-first parallel-to-serial transmitter with start/ready/done handshake.
module serial_tx_8_bit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic [CNT_W-1:0] len,
    output logic             so,
    output logic             busy,
    output logic             ready,
    output logic             done
);

    serial_pkg::tx_state_t state_q;
    serial_pkg::tx_state_t state_d;

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    logic             load_c;
    logic             shift_c;
    logic             cnt_last;
    logic [CNT_W-1:0] len_eff_c;

    assign len_eff_c = serial_pkg::eff_len(len);

    // Next-state and datapath control; en only gates progress while shifting.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        load_c  = 1'b0;
        shift_c = 1'b0;
        case (state_q)
            serial_pkg::IDLE: begin
                if (start) begin
                    load_c  = 1'b1;
                    sr_d    = din;
                    state_d = serial_pkg::SHIFT;
                end
            end
            serial_pkg::SHIFT: begin
                if (en) begin
                    shift_c = 1'b1;
                    sr_d    = {sr_q[WIDTH-2:0], 1'b0};
                    if (cnt_last) begin
                        state_d = serial_pkg::DONE;
                    end
                end
            end
            serial_pkg::DONE: begin
                state_d = serial_pkg::IDLE;
            end
            default: begin
                state_d = serial_pkg::IDLE;
            end
        endcase
    end

    // State register; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= serial_pkg::IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shift register holding the not-yet-sent bits, current bit at the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    bit_down_counter #(
        .CNT_W (CNT_W)
    ) u_bit_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (load_c),
        .en   (shift_c),
        .init (len_eff_c),
        .last (cnt_last)
    );

    // Handshake flags decode straight from the state register.
    assign busy  = (state_q == serial_pkg::SHIFT);
    assign ready = (state_q == serial_pkg::IDLE);
    assign done  = (state_q == serial_pkg::DONE);
    assign so    = busy & sr_q[WIDTH-1];

endmodule : serial_tx_8_bit

// File: tb/tb_serial_tx_8_bit.sv
// Scoreboard bench for serial_tx_8_bit with a bench-side receiver shift register.
module tb_serial_tx_8_bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       en;
    logic [7:0] din;
    logic [3:0] len;
    logic       so;
    logic       busy;
    logic       ready;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    bit         exp_q[$];
    logic [7:0] rx_q;

    serial_tx_8_bit #(
        .WIDTH (8),
        .CNT_W (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .en    (en),
        .din   (din),
        .len   (len),
        .so    (so),
        .busy  (busy),
        .ready (ready),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Receiver end of the link: samples so on the edge where the transmitter shifts.
    always @(posedge clk) begin
        if (!rst && ready && start) begin
            rx_q <= 8'h00;
        end else if (!rst && busy && en) begin
            rx_q <= {rx_q[6:0], so};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int eff(input logic [3:0] l);
        return ((l == 4'd0) || (l > 4'd8)) ? 8 : int'(l);
    endfunction

    // Send one frame; en drops for stall_n cycles once stall_at bits are out.
    task automatic send(input logic [7:0] d, input logic [3:0] l,
                        input int stall_at, input int stall_n, input bit poke);
        int L       = eff(l);
        int sent    = 0;
        int stalled = 0;
        int cycles  = 0;
        bit fin     = 1'b0;
        int rx_exp;
        int rx_got;
        for (int i = 0; i < L; i++) exp_q.push_back(d[7-i]);
        din   = d;
        len   = l;
        start = 1'b1;
        en    = 1'b1;
        @(negedge clk);
        check("ready_before_start", 32'(ready), 32'd1);
        cyc();
        start = 1'b0;
        din   = ~d;
        len   = 4'd1;
        while (!fin && cycles < 40) begin
            en    = (sent == stall_at && stalled < stall_n) ? 1'b0 : 1'b1;
            start = poke && (sent == 1 || sent == L);
            @(negedge clk);
            if (!busy) begin
                fin = 1'b1;
            end else begin
                cycles++;
                if (exp_q.size() == 0) begin
                    check("extra_shift_cycle", 32'(so), 32'hFFFF);
                end else if (en) begin
                    check("so_bit", 32'(so), 32'(exp_q.pop_front()));
                    sent++;
                end else begin
                    check("so_hold_stall", 32'(so), 32'(exp_q[0]));
                    stalled++;
                end
                cyc();
            end
        end
        if (!fin) begin
            check("frame_timeout", 32'd0, 32'd1);
        end else begin
            check("frame_cycles", 32'(cycles), 32'(L + stall_n));
            check("done_pulse", 32'(done), 32'd1);
            check("so_in_done", 32'(so), 32'd0);
            check("ready_in_done", 32'(ready), 32'd0);
            check("bits_left", 32'(exp_q.size()), 32'd0);
            rx_exp = int'(d) >> (8 - L);
            rx_got = int'(rx_q) & ((1 << L) - 1);
            check("rx_data", 32'(rx_got), 32'(rx_exp));
        end
        exp_q.delete();
        cyc();
        start = 1'b0;
        en    = 1'b1;
        @(negedge clk);
        check("ready_after_done", 32'(ready), 32'd1);
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        int dcount;
        rst   = 1'b1;
        start = 1'b0;
        en    = 1'b0;
        din   = 8'h00;
        len   = 4'd0;
        cyc();
        cyc();
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_so", 32'(so), 32'd0);

        // start together with reset is dropped
        start = 1'b1;
        din   = 8'hFF;
        cyc();
        rst   = 1'b0;
        start = 1'b0;
        en    = 1'b1;
        @(negedge clk);
        check("rst_start_drop_busy", 32'(busy), 32'd0);
        check("rst_start_drop_ready", 32'(ready), 32'd1);
        cyc();

        send(8'hB5, 4'd0, -1, 0, 1'b0);
        send(8'hC0, 4'd3, 1, 2, 1'b0);
        send(8'hA7, 4'd12, -1, 0, 1'b1);
        send(8'h6D, 4'd8, -1, 0, 1'b0);
        send(8'h80, 4'd1, -1, 0, 1'b1);
        send(8'h3C, 4'd15, 7, 3, 1'b0);
        for (int n = 0; n < 6; n++) begin
            logic [7:0] rd;
            logic [3:0] rl;
            rd = 8'($urandom);
            rl = 4'($urandom_range(0, 15));
            send(rd, rl, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'($urandom));
        end

        // reset after three bits abandons the frame
        din   = 8'hB5;
        len   = 4'd0;
        start = 1'b1;
        en    = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_so", 32'(so), 32'd0);
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("midrst_no_done", 32'(dcount), 32'd0);
        cyc();

        send(8'h5A, 4'd4, -1, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_tx_8_bit
